// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, default matrix size
// and the all-ones row code the decoder treats as an invalid (multi-row) press.
package keypad_pkg;

    localparam int KEY_ROW_DEF = 4;
    localparam int KEY_COL_DEF = 4;

    // Cast down to the row width at the point of use.
    localparam logic [31:0] ROW_INVALID = '1;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin and decoder-side signals of the keypad scanner; master is the scanner,
// slave is the keypad/decoder side.
interface keypad_scanner_if
    import keypad_pkg::*;
#(
    parameter int KEY_ROW = KEY_ROW_DEF,
    parameter int KEY_COL = KEY_COL_DEF
);
    logic [KEY_ROW-1:0] row_sense;
    logic [KEY_COL-1:0] col_drive;
    logic [KEY_ROW-1:0] row;
    logic [KEY_COL-1:0] col;
    logic               key_in;
    logic               busy;

    modport master (
        input  row_sense,
        output col_drive, row, col, key_in, busy
    );

    modport slave (
        output row_sense,
        input  col_drive, row, col, key_in, busy
    );
endinterface

// File: rtl/keypad_debounce.sv
// Stable-pattern counter: counts consecutive cycles where i_data equals i_ref and
// flags o_done on the cycle the count reaches DEBOUNCE_CNT.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int WIDTH        = KEY_ROW_DEF,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_ref,
    output logic             o_match,
    output logic             o_done
);
    logic [DEBOUNCE_CNT-1:0] r_cnt;

    assign o_match = (i_data == i_ref);
    assign o_done  = i_en && o_match && (r_cnt == DEBOUNCE_CNT'(DEBOUNCE_CNT - 1));

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_match ? r_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and a one-cycle key_in strobe.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int KEY_ROW      = KEY_ROW_DEF,
    parameter int KEY_COL      = KEY_COL_DEF,
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_CNT   = 256
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master bus
);
    localparam int                 DWELL_W = $clog2(SCAN_DIV);
    localparam logic [KEY_ROW-1:0] ROW_BAD = KEY_ROW'(ROW_INVALID);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 2) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV>=2, DEBOUNCE_CNT>=1, REPEAT_CNT>=2 required");
    end

    state_t             r_state, w_next_state;
    logic [KEY_ROW-1:0] r_sync, r_rs, r_pat, r_row, w_row_idx;
    logic [KEY_COL-1:0] r_c, w_c_next, r_col_drive, r_col;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_key_in, r_busy;
    logic               w_advance, w_latch, w_strobe, w_onehot;
    logic               w_db_en, w_db_clr, w_db_match, w_db_done;
    logic [KEY_ROW-1:0] w_db_ref;

    // One debounce counter serves both phases: press compares against pat, release against 0.
    assign w_db_ref = (r_state == ST_HOLD) ? '0 : r_pat;
    assign w_db_en  = (r_state != ST_SCAN);
    assign w_db_clr = (w_next_state != r_state);

    keypad_debounce #(
        .WIDTH        (KEY_ROW),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_db_en),
        .i_clr   (w_db_clr),
        .i_data  (r_rs),
        .i_ref   (w_db_ref),
        .o_match (w_db_match),
        .o_done  (w_db_done)
    );

    assign w_c_next = (r_c == KEY_COL'(KEY_COL - 1)) ? '0 : r_c + 1'b1;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CNT);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_stop, w_rep_fire;

    assign w_rep_fire = (r_state == ST_HOLD) && !r_rep_stop && (r_rs == r_pat)
                        && (r_rep_cnt == REP_W'(REPEAT_CNT - 1));

    // A different nonzero pattern while held latches r_rep_stop until the key is released.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_HOLD) begin
            r_rep_cnt  <= '0;
            r_rep_stop <= 1'b0;
        end else begin
            if (r_rs != '0 && r_rs != r_pat) r_rep_stop <= 1'b1;
            if (w_strobe || r_rs != r_pat) r_rep_cnt <= '0;
            else if (!r_rep_stop)          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_onehot  = (r_pat != '0) && ((r_pat & (r_pat - 1'b1)) == '0);
        w_row_idx = ROW_BAD;
        if (w_onehot) begin
            for (int i = 0; i < KEY_ROW; i++) begin
                if (r_pat[i]) w_row_idx = KEY_ROW'(i);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        w_latch      = 1'b0;
        w_strobe     = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell == DWELL_W'(SCAN_DIV - 1)) begin
                    if (r_rs != '0) begin
                        w_next_state = ST_DEBOUNCE;
                        w_latch      = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (!w_db_match) begin
                    w_next_state = ST_SCAN;
                    w_advance    = 1'b1;
                end else if (w_db_done) begin
                    w_next_state = ST_HOLD;
                    w_strobe     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_db_done) begin
                    w_next_state = ST_SCAN;
                    w_advance    = 1'b1;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (w_rep_fire) begin
                    w_strobe = 1'b1;
                end
`endif
            end
            default: w_next_state = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_SCAN;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= '0;
            r_rs        <= '0;
            r_pat       <= '0;
            r_c         <= '0;
            r_col_drive <= KEY_COL'(1);
            r_dwell     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_key_in    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync <= bus.row_sense;
            r_rs   <= r_sync;
            if (w_advance) begin
                r_c         <= w_c_next;
                r_col_drive <= KEY_COL'(1) << w_c_next;
                r_dwell     <= '0;
            end else if (w_latch) begin
                r_pat   <= r_rs;
                r_dwell <= '0;
            end else if (r_state == ST_SCAN) begin
                r_dwell <= r_dwell + 1'b1;
            end
            r_key_in <= w_strobe;
            if (w_strobe) begin
                r_row <= w_row_idx;
                r_col <= r_c;
            end
            r_busy <= (w_next_state != ST_SCAN);
        end
    end

    assign bus.col_drive = r_col_drive;
    assign bus.row       = r_row;
    assign bus.col       = r_col;
    assign bus.key_in    = r_key_in;
    assign bus.busy      = r_busy;
endmodule
